// File: rtl/butterfly_tw.sv
// Pipelined radix-2 DIT butterfly with run-time W8^k twiddle, valid/ready flow control,
// optional divide-by-2 scaling and saturation with a sticky overflow flag.
module butterfly_tw #(
    parameter int N     = 4,
    parameter int SCALE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_k,
    input  logic [2**N-1:0]   in_a_r,
    input  logic [2**N-1:0]   in_a_i,
    input  logic [2**N-1:0]   in_b_r,
    input  logic [2**N-1:0]   in_b_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_1_r,
    output logic [2**N-1:0]   out_1_i,
    output logic [2**N-1:0]   out_2_r,
    output logic [2**N-1:0]   out_2_i,
    input  logic              ovf_clr,
    output logic              ovf
);
    localparam int W = 2**N;
    localparam real K_REAL = (2.0 ** (W - 1)) / $sqrt(2.0);
    localparam logic signed [W:0]   K_S   = (W+1)'($rtoi(K_REAL + 0.5));
    localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    function automatic logic signed [W+1:0] scale_fn(input logic signed [W+1:0] x);
        if (SCALE != 0) return x >>> 1;
        return x;
    endfunction

    function automatic logic is_sat(input logic signed [W+1:0] x);
        return (x > MAX_V) || (x < MIN_V);
    endfunction

    function automatic logic [W-1:0] clip(input logic signed [W+1:0] x);
        if (x > MAX_V) return {1'b0, {(W-1){1'b1}}};
        if (x < MIN_V) return {1'b1, {(W-1){1'b0}}};
        return x[W-1:0];
    endfunction

    logic                  advance;
    logic signed [W:0]     br_x, bi_x, s_r_c, s_i_c;
    logic signed [2*W-1:0] prod_r, prod_i;
    logic signed [W:0]     rot_r_c, rot_i_c;
    logic signed [W+1:0]   sum_1r, sum_1i, sum_2r, sum_2i;
    logic                  any_sat;
    logic                  unused_lsbs;

    logic                  v1_q, v1_d, odd1_q, odd1_d;
    logic signed [W-1:0]   a1_r_q, a1_r_d, a1_i_q, a1_i_d;
    logic signed [W:0]     s1_r_q, s1_r_d, s1_i_q, s1_i_d;
    logic                  v2_q, v2_d;
    logic signed [W-1:0]   a2_r_q, a2_r_d, a2_i_q, a2_i_d;
    logic signed [W:0]     rot_r_q, rot_r_d, rot_i_q, rot_i_d;
    logic                  v3_q, v3_d, ovf_q, ovf_d;
    logic [W-1:0]          o1_r_q, o1_r_d, o1_i_q, o1_i_d, o2_r_q, o2_r_d, o2_i_q, o2_i_d;

    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign out_1_r   = o1_r_q;
    assign out_1_i   = o1_i_q;
    assign out_2_r   = o2_r_q;
    assign out_2_i   = o2_i_q;
    assign ovf       = ovf_q;

    assign br_x = {in_b_r[W-1], in_b_r};
    assign bi_x = {in_b_i[W-1], in_b_i};

    // Rotation by multiples of 90 degrees, plus the pre-sums that odd k later scales by 1/sqrt(2)
    always_comb begin
        s_r_c = br_x;
        s_i_c = bi_x;
        case (in_k)
            3'd0: begin s_r_c = br_x;         s_i_c = bi_x;         end
            3'd1: begin s_r_c = br_x + bi_x;  s_i_c = bi_x - br_x;  end
            3'd2: begin s_r_c = bi_x;         s_i_c = -br_x;        end
            3'd3: begin s_r_c = bi_x - br_x;  s_i_c = -br_x - bi_x; end
            3'd4: begin s_r_c = -br_x;        s_i_c = -bi_x;        end
            3'd5: begin s_r_c = -br_x - bi_x; s_i_c = br_x - bi_x;  end
            3'd6: begin s_r_c = -bi_x;        s_i_c = br_x;         end
            3'd7: begin s_r_c = br_x - bi_x;  s_i_c = br_x + bi_x;  end
            default: ;
        endcase
    end

    assign prod_r      = (2*W)'(s1_r_q) * (2*W)'(K_S);
    assign prod_i      = (2*W)'(s1_i_q) * (2*W)'(K_S);
    assign rot_r_c     = odd1_q ? prod_r[2*W-1:W-1] : s1_r_q;
    assign rot_i_c     = odd1_q ? prod_i[2*W-1:W-1] : s1_i_q;
    assign unused_lsbs = ^{prod_r[W-2:0], prod_i[W-2:0]};

    assign sum_1r  = scale_fn((W+2)'(a2_r_q) + (W+2)'(rot_r_q));
    assign sum_1i  = scale_fn((W+2)'(a2_i_q) + (W+2)'(rot_i_q));
    assign sum_2r  = scale_fn((W+2)'(a2_r_q) - (W+2)'(rot_r_q));
    assign sum_2i  = scale_fn((W+2)'(a2_i_q) - (W+2)'(rot_i_q));
    assign any_sat = is_sat(sum_1r) || is_sat(sum_1i) || is_sat(sum_2r) || is_sat(sum_2i);

    // The whole pipe moves as one; data registers only load behind a valid beat
    always_comb begin
        v1_d    = v1_q;    odd1_d  = odd1_q;
        a1_r_d  = a1_r_q;  a1_i_d  = a1_i_q;
        s1_r_d  = s1_r_q;  s1_i_d  = s1_i_q;
        v2_d    = v2_q;
        a2_r_d  = a2_r_q;  a2_i_d  = a2_i_q;
        rot_r_d = rot_r_q; rot_i_d = rot_i_q;
        v3_d    = v3_q;
        o1_r_d  = o1_r_q;  o1_i_d  = o1_i_q;
        o2_r_d  = o2_r_q;  o2_i_d  = o2_i_q;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;
        if (advance) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            if (in_valid) begin
                a1_r_d = in_a_r;
                a1_i_d = in_a_i;
                odd1_d = in_k[0];
                s1_r_d = s_r_c;
                s1_i_d = s_i_c;
            end
            if (v1_q) begin
                a2_r_d  = a1_r_q;
                a2_i_d  = a1_i_q;
                rot_r_d = rot_r_c;
                rot_i_d = rot_i_c;
            end
            if (v2_q) begin
                o1_r_d = clip(sum_1r);
                o1_i_d = clip(sum_1i);
                o2_r_d = clip(sum_2r);
                o2_i_d = clip(sum_2i);
                if (any_sat) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0; odd1_q  <= 1'b0;
            a1_r_q  <= '0;   a1_i_q  <= '0;
            s1_r_q  <= '0;   s1_i_q  <= '0;
            v2_q    <= 1'b0;
            a2_r_q  <= '0;   a2_i_q  <= '0;
            rot_r_q <= '0;   rot_i_q <= '0;
            v3_q    <= 1'b0;
            o1_r_q  <= '0;   o1_i_q  <= '0;
            o2_r_q  <= '0;   o2_i_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;    odd1_q  <= odd1_d;
            a1_r_q  <= a1_r_d;  a1_i_q  <= a1_i_d;
            s1_r_q  <= s1_r_d;  s1_i_q  <= s1_i_d;
            v2_q    <= v2_d;
            a2_r_q  <= a2_r_d;  a2_i_q  <= a2_i_d;
            rot_r_q <= rot_r_d; rot_i_q <= rot_i_d;
            v3_q    <= v3_d;
            o1_r_q  <= o1_r_d;  o1_i_q  <= o1_i_d;
            o2_r_q  <= o2_r_d;  o2_i_q  <= o2_i_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: doc/butterfly_tw.md
# butterfly_tw

Pipelined, parametrised radix-2 decimation-in-time butterfly with a run-time selectable 8th-root-of-unity twiddle W8^k and a valid/ready handshake. Each accepted transaction computes out_1 = a + W8^k·b and out_2 = a − W8^k·b. Optional ÷2 scaling and output saturation with a sticky overflow flag are included. It replaces fixed-twiddle butterflies in the FFT datapath, so one instance can serve every stage of an 8-point FFT.

## Interface

- N, default 4: data width W = 2**N bits per real/imag component, two's complement.
- SCALE, default 0: 1 = arithmetic shift right by 1 before saturation; 0 = no scaling.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_k  in  3  twiddle index k, 0..7, W8^k = exp(−j·2πk/8).
- in_a_r, in_a_i, in_b_r, in_b_i  in  W  operands a and b.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_1_r, out_1_i, out_2_r, out_2_i  out  W  results.
- ovf_clr  in  1  synchronous clear of ovf.
- ovf  out  1  sticky saturation flag.

## Operation

- Constant K = round(2^(W−1)/√2), W bits unsigned. For N=4, K = 23170.
- Stage 1 (rotate-sum): register a, k, and the (W+1)-bit sums/differences needed by k:
  - k=0: (br, bi)
  - k=2: (bi, −br)
  - k=4: (−br, −bi)
  - k=6: (−bi, br)
  - k=1: (br+bi, bi−br)
  - k=3: (bi−br, −br−bi)
  - k=5: (−br−bi, br−bi)
  - k=7: (br−bi, br+bi)
- Stage 2 (scale): for odd k, each component = (sum·K) >>> (W−1), arithmetic shift with floor truncation. Even k passes through unchanged. Result rot is W+1 bits, so −(−2^(W−1)) is exact.
- Stage 3 (combine): form a ± rot at W+2 bits. If SCALE=1, apply >>>1 (floor). Saturate each of the four components to [−2^(W−1), 2^(W−1)−1] and register.
- ovf is set on any cycle a result is loaded into stage 3 with at least one component saturated. It holds until reset or ovf_clr. If set and ovf_clr occur in the same cycle, set wins.
- Stall: advance = !out_valid || out_ready.
  - When advance = 0, every stage register and valid bit holds.
  - When advance = 1, all stages shift, and bubbles propagate as valid = 0.
- in_ready = advance, combinational from out_valid and out_ready only. There is no combinational path from in_valid to in_ready.
- A transfer occurs on in_valid && in_ready. Output is consumed on out_valid && out_ready.

## Timing

- Latency: exactly 3 cycles from the accepting edge to out_valid = 1 when unstalled. Throughput is 1 transaction per cycle.
- Reset (rst low, asynchronous) clears:
  - all valid bits to 0
  - out_1_r, out_1_i, out_2_r, out_2_i, and ovf to 0
  - all internal data registers to 0
- in_ready = 1 immediately after reset.
- Reset during a stall or with data in flight discards all in-flight transactions. No output is produced for them.
- out_* data are stable while out_valid && !out_ready.
- When out_valid = 0, out_* retain the last loaded value. The value is don't-care to consumers.
- Back-to-back transfers with out_ready held high produce results in order, with no gaps and no duplicates.
- ovf_clr is sampled on the rising edge and affects ovf on the next cycle.

## Test plan

- N=4, SCALE=0, a=(1000,0), b=(1000,0), k=1 → after 3 cycles out_1=(1707,−708), out_2=(293,708), ovf=0.
- Sweep k=0..7 with a=(0,0), b=(1000,0) → out_1 equals:
  - k=0: (1000, 0)
  - k=1: (707, −708)
  - k=2: (0, −1000)
  - k=3: (−708, −708)
  - k=4: (−1000, 0)
  - k=5: (−708, 707)
  - k=6: (0, 1000)
  - k=7: (707, 707)

  In every case out_2 = −out_1. Results arrive on 8 consecutive cycles.
- Saturation, SCALE=0:
  - a=(32767,0), b=(32767,0), k=0 → out_1_r=32767, out_2_r=0, ovf=1.
  - Then ovf_clr for one cycle → ovf=0.
  - a=0, b=(−32768,0), k=4 → out_1_r=32767, out_2_r=−32768, ovf=1.
- SCALE=1, a=(32767,0), b=(32767,0), k=0 → out_1_r=32767, out_2_r=0, ovf=0. With a=(3,0), b=(0,0), k=0 → out_1_r=1, out_2_r=1.
- Backpressure: stream 6 transactions with out_ready toggling randomly → in_ready = !out_valid || out_ready every cycle, all 6 results in order, outputs stable while stalled.
- Reset mid-stream: assert rst with 3 transactions in flight → out_valid=0, outputs=0, ovf=0 immediately. After release the next transaction has 3-cycle latency and no stale results appear.
